// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- hazard controller for the 5-stage RV32I pipeline.
//
// Detects load-use hazards, flushes the front end on taken control transfers
// and freezes the whole pipeline while data memory is not ready. Outputs are
// combinational from the FSM state and the current inputs, so a hazard takes
// effect in the same cycle it appears.
//
// Parameters:
//   DATA_WIDTH   instruction width (RV32I decode assumes 32)
//   LOAD_LAT     load-use stall cycles per hazard, 1..15
//   FLUSH_DEPTH  IF/ID flush cycles after a taken branch/jump, 1..15
//   CNT_WIDTH    perf counter width (only with HAZARD_PERF_CNT_EN)
//
// Ports:
//   clk_i        clock
//   rst_i        synchronous reset, active high
//   br_sel_i     EX-stage branch/jump is taken
//   ex_inst_i    instruction in EX
//   mem_inst_i   instruction in MEM
//   dmem_rdy_i   data memory accepts/returns this cycle
//   hold_o       [0]PC [1]IF/ID [2]ID/EX [3]EX/MEM [4]MEM/WB keep value
//   flush_o      [0]IF/ID [1]ID/EX [2]EX/MEM load NOP bubble
//   stall_o      00 none, 01 data, 10 control, 11 mem wait
//
// Optional build macro HAZARD_PERF_CNT_EN adds saturating cycle counters
// stall_cyc_o / flush_cyc_o / wait_cyc_o for stall codes 01 / 10 / 11.

module hazard_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int LOAD_LAT    = 1,
  parameter int FLUSH_DEPTH = 1,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  br_sel_i,
  input  logic [DATA_WIDTH-1:0] ex_inst_i,
  input  logic [DATA_WIDTH-1:0] mem_inst_i,
  input  logic                  dmem_rdy_i,
  output logic [4:0]            hold_o,
  output logic [2:0]            flush_o,
  output logic [1:0]            stall_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  stall_cyc_o,
  output logic [CNT_WIDTH-1:0]  flush_cyc_o,
  output logic [CNT_WIDTH-1:0]  wait_cyc_o
`endif
);

  typedef enum logic [1:0] {
    S_RUN,
    S_LD_STALL,
    S_FLUSH
  } state_t;

  localparam logic [4:0] OP_LOAD  = 5'b00000;
  localparam logic [4:0] OP_STORE = 5'b01000;
  localparam logic [4:0] OP_BR    = 5'b11000;
  localparam logic [4:0] OP_JALR  = 5'b11001;
  localparam logic [4:0] OP_JAL   = 5'b11011;

  state_t     state;
  logic [3:0] cnt;

  // Decode fields
  logic [4:0] ex_op, ex_rs1, ex_rs2, mem_op, mem_rd;
  assign ex_op  = ex_inst_i[6:2];
  assign ex_rs1 = ex_inst_i[19:15];
  assign ex_rs2 = ex_inst_i[24:20];
  assign mem_op = mem_inst_i[6:2];
  assign mem_rd = mem_inst_i[11:7];

  // Remaining instruction bits carry no hazard information.
  logic unused_inst_bits;
  assign unused_inst_bits = ^{ex_inst_i, mem_inst_i};

  logic mem_is_load, mem_is_store, ex_is_ctrl;
  logic ev_wait, ev_ldu, ev_brt;

  assign mem_is_load  = (mem_op == OP_LOAD);
  assign mem_is_store = (mem_op == OP_STORE);
  assign ex_is_ctrl   = (ex_op == OP_BR) || (ex_op == OP_JALR) || (ex_op == OP_JAL);

  assign ev_wait = (mem_is_load || mem_is_store) && !dmem_rdy_i;
  assign ev_ldu  = mem_is_load && (mem_rd != 5'd0) &&
                   ((mem_rd == ex_rs1) || (mem_rd == ex_rs2));
  assign ev_brt  = br_sel_i && ex_is_ctrl;

  // Output decode. Memory wait overrides everything; in RUN a load-use
  // hazard beats a taken branch, which stays in EX and is re-evaluated later.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would infer a latch.
    hold_o  = 5'b00000;
    flush_o = 3'b000;
    stall_o = 2'b00;
    if (rst_i) begin
      // all zero while in reset
    end else if (ev_wait) begin
      hold_o  = 5'b11111;
      stall_o = 2'b11;
    end else begin
      unique case (state)
        S_RUN: begin
          if (ev_ldu) begin
            hold_o  = 5'b00111;
            flush_o = 3'b100;
            stall_o = 2'b01;
          end else if (ev_brt) begin
            flush_o = 3'b011;
            stall_o = 2'b10;
          end
        end
        S_LD_STALL: begin
          hold_o  = 5'b00111;
          flush_o = 3'b100;
          stall_o = 2'b01;
        end
        S_FLUSH: begin
          flush_o = 3'b001;
          stall_o = 2'b10;
        end
        default: ;
      endcase
    end
  end

  // State and down-counter. The RUN cycle that detects the event is the first
  // of the LOAD_LAT / FLUSH_DEPTH cycles, so the counter loads with N-1.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst_i) begin
      state <= S_RUN;
      cnt   <= 4'd0;
    end else if (!ev_wait) begin
      unique case (state)
        S_RUN: begin
          if (ev_ldu) begin
            if (LOAD_LAT > 1) begin
              state <= S_LD_STALL;
              cnt   <= 4'(LOAD_LAT - 1);
            end
          end else if (ev_brt) begin
            if (FLUSH_DEPTH > 1) begin
              state <= S_FLUSH;
              cnt   <= 4'(FLUSH_DEPTH - 1);
            end
          end
        end
        S_LD_STALL, S_FLUSH: begin
          if (cnt == 4'd1) begin
            state <= S_RUN;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state <= S_RUN;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Saturating cycle counters per stall class.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cyc_o <= '0;
      flush_cyc_o <= '0;
      wait_cyc_o  <= '0;
    end else begin
      if (stall_o == 2'b01 && stall_cyc_o != '1)
        stall_cyc_o <= stall_cyc_o + CNT_WIDTH'(1);
      if (stall_o == 2'b10 && flush_cyc_o != '1)
        flush_cyc_o <= flush_cyc_o + CNT_WIDTH'(1);
      if (stall_o == 2'b11 && wait_cyc_o != '1)
        wait_cyc_o <= wait_cyc_o + CNT_WIDTH'(1);
    end
  end
`else
  localparam int unused_cnt_width = CNT_WIDTH;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl -- directed bench for hazard_ctrl.
// Two instances share the stimulus: dut_a (LOAD_LAT=1, FLUSH_DEPTH=1) and
// dut_b (LOAD_LAT=3, FLUSH_DEPTH=2). Observed values are {hold, flush, stall}.

module tb_hazard_ctrl;

  localparam logic [9:0] O_NONE = 10'b00000_000_00;
  localparam logic [9:0] O_DATA = 10'b00111_100_01;
  localparam logic [9:0] O_BRT  = 10'b00000_011_10;
  localparam logic [9:0] O_FLSH = 10'b00000_001_10;
  localparam logic [9:0] O_WAIT = 10'b11111_000_11;

  localparam logic [31:0] I_NOP      = 32'h0000_0013; // addi x0,x0,0
  localparam logic [31:0] I_LW_X5    = 32'h0000_A283; // lw   x5,0(x1)
  localparam logic [31:0] I_LW_X0    = 32'h0000_A003; // lw   x0,0(x1)
  localparam logic [31:0] I_ADD_RS1  = 32'h0012_8333; // add  x6,x5,x1
  localparam logic [31:0] I_ADD_RS2  = 32'h0050_8333; // add  x6,x1,x5
  localparam logic [31:0] I_ADD_X0   = 32'h0000_0333; // add  x6,x0,x0
  localparam logic [31:0] I_BEQ      = 32'h0020_8063; // beq  x1,x2,0
  localparam logic [31:0] I_BEQ_X5   = 32'h0022_8063; // beq  x5,x2,0
  localparam logic [31:0] I_JAL      = 32'h0000_00EF; // jal  x1,0
  localparam logic [31:0] I_SW       = 32'h0050_A2A3; // sw   x5,5(x1)

  logic        clk;
  logic        rst;
  logic        br_sel;
  logic [31:0] ex_inst;
  logic [31:0] mem_inst;
  logic        dmem_rdy;
  logic [4:0]  hold_a, hold_b;
  logic [2:0]  flush_a, flush_b;
  logic [1:0]  stall_a, stall_b;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cyc_a, flush_cyc_a, wait_cyc_a;
  logic [15:0] stall_cyc_b, flush_cyc_b, wait_cyc_b;
`endif

  int checks   = 0;
  int failures = 0;

  hazard_ctrl #(.DATA_WIDTH(32), .LOAD_LAT(1), .FLUSH_DEPTH(1), .CNT_WIDTH(16)) dut_a (
    .clk_i(clk), .rst_i(rst), .br_sel_i(br_sel),
    .ex_inst_i(ex_inst), .mem_inst_i(mem_inst), .dmem_rdy_i(dmem_rdy),
    .hold_o(hold_a), .flush_o(flush_a), .stall_o(stall_a)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cyc_o(stall_cyc_a), .flush_cyc_o(flush_cyc_a), .wait_cyc_o(wait_cyc_a)
`endif
  );

  hazard_ctrl #(.DATA_WIDTH(32), .LOAD_LAT(3), .FLUSH_DEPTH(2), .CNT_WIDTH(16)) dut_b (
    .clk_i(clk), .rst_i(rst), .br_sel_i(br_sel),
    .ex_inst_i(ex_inst), .mem_inst_i(mem_inst), .dmem_rdy_i(dmem_rdy),
    .hold_o(hold_b), .flush_o(flush_b), .stall_o(stall_b)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cyc_o(stall_cyc_b), .flush_cyc_o(flush_cyc_b), .wait_cyc_o(wait_cyc_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_both(input string tag, input logic [9:0] exp_a, input logic [9:0] exp_b);
    check({tag, "/a"}, {hold_a, flush_a, stall_a}, exp_a);
    check({tag, "/b"}, {hold_b, flush_b, stall_b}, exp_b);
  endtask

  // Apply inputs just after a rising edge, then let combinational outputs settle.
  task automatic drive(input logic r, input logic br, input logic [31:0] ex,
                       input logic [31:0] mem, input logic rdy);
    rst      = r;
    br_sel   = br;
    ex_inst  = ex;
    mem_inst = mem;
    dmem_rdy = rdy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b1, 1'b0, I_NOP, I_NOP, 1'b1);
    tick();
    tick();
    // Reset dominates even with a hazard on the inputs.
    drive(1'b1, 1'b1, I_ADD_RS1, I_LW_X5, 1'b0);
    check_both("reset_outputs", O_NONE, O_NONE);
    tick();

    // T1/T2: load-use via rs1; a stalls 1 cycle, b stalls 3.
    drive(1'b0, 1'b0, I_ADD_RS1, I_LW_X5, 1'b1);
    check_both("ldu_c0", O_DATA, O_DATA);
    tick();
    drive(1'b0, 1'b0, I_ADD_RS1, I_NOP, 1'b1);
    check_both("ldu_c1", O_NONE, O_DATA);
    tick();
    drive(1'b0, 1'b0, I_ADD_RS1, I_NOP, 1'b1);
    check_both("ldu_c2", O_NONE, O_DATA);
    tick();
    // T3: b must be in RUN here, so a taken beq flushes on both.
    drive(1'b0, 1'b1, I_BEQ, I_NOP, 1'b1);
    check_both("brt_c0", O_BRT, O_BRT);
    tick();
    drive(1'b0, 1'b0, I_NOP, I_NOP, 1'b1);
    check_both("brt_c1", O_NONE, O_FLSH);
    tick();
    drive(1'b0, 1'b0, I_NOP, I_NOP, 1'b1);
    check_both("brt_c2", O_NONE, O_NONE);
    tick();

    // br_sel with a non-control instruction in EX does nothing.
    drive(1'b0, 1'b1, I_ADD_X0, I_NOP, 1'b1);
    check_both("brsel_nonctrl", O_NONE, O_NONE);
    tick();

    // T4: store waiting on memory with a taken jal in EX.
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, I_JAL, I_SW, 1'b0);
      check_both($sformatf("wait_c%0d", i), O_WAIT, O_WAIT);
      tick();
    end
    drive(1'b0, 1'b1, I_JAL, I_SW, 1'b1);
    check_both("wait_release", O_BRT, O_BRT);
    tick();
    drive(1'b0, 1'b0, I_NOP, I_NOP, 1'b1);
    check_both("wait_flush_tail", O_NONE, O_FLSH);
    tick();
    // Store whose imm field equals EX rs1 is not a load-use hazard.
    drive(1'b0, 1'b0, I_ADD_RS1, I_SW, 1'b1);
    check_both("store_no_ldu", O_NONE, O_NONE);
    tick();

    // Memory wait freezes b's load-use counter.
    drive(1'b0, 1'b0, I_ADD_RS1, I_LW_X5, 1'b1);
    check_both("frz_c0", O_DATA, O_DATA);
    tick();
    drive(1'b0, 1'b0, I_ADD_RS1, I_LW_X5, 1'b0);
    check_both("frz_w0", O_WAIT, O_WAIT);
    tick();
    drive(1'b0, 1'b0, I_ADD_RS1, I_LW_X5, 1'b0);
    check_both("frz_w1", O_WAIT, O_WAIT);
    tick();
    drive(1'b0, 1'b0, I_NOP, I_NOP, 1'b1);
    check_both("frz_c1", O_NONE, O_DATA);
    tick();
    drive(1'b0, 1'b0, I_NOP, I_NOP, 1'b1);
    check_both("frz_c2", O_NONE, O_DATA);
    tick();
    drive(1'b0, 1'b0, I_NOP, I_NOP, 1'b1);
    check_both("frz_done", O_NONE, O_NONE);
    tick();

    // T5: simultaneous ldu and brt; data stall wins, branch re-evaluated.
    drive(1'b0, 1'b1, I_BEQ_X5, I_LW_X5, 1'b1);
    check_both("both_c0", O_DATA, O_DATA);
    tick();
    drive(1'b0, 1'b1, I_BEQ_X5, I_NOP, 1'b1);
    check_both("both_c1", O_BRT, O_DATA);
    tick();
    drive(1'b0, 1'b1, I_BEQ_X5, I_NOP, 1'b1);
    check_both("both_c2", O_BRT, O_DATA);
    tick();
    drive(1'b0, 1'b1, I_BEQ_X5, I_NOP, 1'b1);
    check_both("both_c3", O_BRT, O_BRT);
    tick();
    drive(1'b0, 1'b0, I_NOP, I_NOP, 1'b1);
    check_both("both_c4", O_NONE, O_FLSH);
    tick();
    // lw x0 never creates a hazard.
    drive(1'b0, 1'b0, I_ADD_X0, I_LW_X0, 1'b1);
    check_both("lw_x0", O_NONE, O_NONE);
    tick();

    // T6: load-use via rs2, then reset while b is in LD_STALL with cnt = 2.
    drive(1'b0, 1'b0, I_ADD_RS2, I_LW_X5, 1'b1);
    check_both("ldu_rs2", O_DATA, O_DATA);
    tick();
    drive(1'b1, 1'b0, I_ADD_RS2, I_LW_X5, 1'b1);
    check_both("rst_mid_stall", O_NONE, O_NONE);
    tick();
    drive(1'b0, 1'b0, I_NOP, I_NOP, 1'b1);
    check_both("post_rst_run", O_NONE, O_NONE);
`ifdef HAZARD_PERF_CNT_EN
    check("perf_clr/a", {hold_a, flush_a, stall_a} | 10'(stall_cyc_a | flush_cyc_a | wait_cyc_a), O_NONE);
    check("perf_clr/b", {hold_b, flush_b, stall_b} | 10'(stall_cyc_b | flush_cyc_b | wait_cyc_b), O_NONE);
`endif
    tick();
    // Still RUN: a fresh hazard starts a new stall on both.
    drive(1'b0, 1'b0, I_ADD_RS1, I_LW_X5, 1'b1);
    check_both("post_rst_ldu", O_DATA, O_DATA);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
